tdr_bank: RTL



---
 rtl/tdr_bank.sv | 101 ++++++++++
 1 files changed

// File: rtl/tdr_bank.sv
// Multi-channel time-domain register: write pulses accumulate a cycle count, read replays it as a pulse.
// Optional TDR_SATURATE_EN: count saturates at 2^WIDTH-1 instead of wrapping.
module tdr_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS-1:0]       we_i,
    input  logic [CHANNELS-1:0]       re_i,
    output logic [CHANNELS-1:0]       out_o,
    output logic [CHANNELS-1:0]       carry_o,
    output logic [CHANNELS-1:0]       rd_done_o,
    output logic [CHANNELS-1:0]       busy_o,
    output logic [CHANNELS*WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, READ} state_t;

    // Returns {overflow, next_count} for one write cycle.
    function automatic logic [WIDTH:0] add_one(input logic [WIDTH-1:0] cnt);
`ifdef TDR_SATURATE_EN
        if (cnt == CNT_MAX) return {1'b1, CNT_MAX};
        else                return {1'b0, cnt + 1'b1};
`else
        return {1'b0, cnt} + 1'b1;
`endif
    endfunction

    logic [CHANNELS-1:0] re_prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) re_prev <= '0;
        else       re_prev <= re_i;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] dcnt;
        logic [WIDTH:0]   inc;
        logic             out_r;
        logic             carry_r;
        logic             done_r;
        logic             busy_r;

        assign inc                        = add_one(count);
        assign count_o[c*WIDTH +: WIDTH]  = count;
        assign out_o[c]                   = out_r;
        assign carry_o[c]                 = carry_r;
        assign rd_done_o[c]               = done_r;
        assign busy_o[c]                  = busy_r;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state   <= IDLE;
                count   <= '0;
                out_r   <= 1'b0;
                carry_r <= 1'b0;
                done_r  <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                done_r <= 1'b0;
                case (state)
                    IDLE: begin
                        // A write in the same cycle as a read edge wins; the edge is dropped.
                        if (we_i[c]) begin
                            count <= inc[WIDTH-1:0];
                            if (inc[WIDTH]) carry_r <= 1'b1;
                        end else if (re_i[c] && !re_prev[c]) begin
                            count   <= '0;
                            carry_r <= 1'b0;
                            dcnt    <= count;
                            if (count != '0) begin
                                state  <= READ;
                                out_r  <= 1'b1;
                                busy_r <= 1'b1;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (dcnt == WIDTH'(1)) begin
                            state  <= IDLE;
                            out_r  <= 1'b0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            dcnt <= dcnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
